// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFADesign access arbiter: control-byte bit
// positions, operand/response field positions and the sequencer states.
package esfa_pkg;

  // Control byte bit positions
  localparam int CTRL_MUTATE = 0;
  localparam int CTRL_META   = 1;
  localparam int CTRL_WRITE  = 2;
  localparam int CTRL_USED_W = 3;

  // Operand fields inside the 32-bit command data word
  localparam int OP_INDEX_LSB = 0;
  localparam int OP_VALUE_LSB = 8;
  localparam int OP_META_LSB  = 16;
  localparam int OP_SEL_LSB   = 24;

  // Response field positions
  localparam int RSP_STATUS_BIT = 0;
  localparam int RSP_VALUE_LSB  = 24;

  // Command sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } esfa_state_e;

endpackage

// File: rtl/esfa_rr_picker.sv
// Combinational round-robin select: first asserted request at or after the
// pointer, wrapping around, returned both one-hot and as an index.
module esfa_rr_picker
  import esfa_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  logic [PTR_W-1:0] cand;

  // Scan requesters starting at the pointer; keep the first hit only
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/esfa_access_arbiter.sv
// Round-robin arbiter and command sequencer in front of the single
// ESFADesign instance. One command is in flight at a time; operand
// registers hold the last values driven into ESFADesign between commands.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | no command; grant a requester and latch its command
//  ST_ISSUE   | update operands / pulse esfa_willWrite for one cycle
//  ST_WAIT    | let ESFADesign settle RESULT_LATENCY cycles, then capture
//  ST_RESPOND | hold response to the granted requester until rsp_ready
module esfa_access_arbiter
  import esfa_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int RESULT_LATENCY = 2
) (
  input  logic                  masterClock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [8*NUM_REQ-1:0]  req_control,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [7:0]            rsp_status,
  output logic [31:0]           rsp_data,
  output logic                  esfa_willWrite,
  output logic                  esfa_isMetadata,
  output logic [7:0]            esfa_new_index,
  output logic [7:0]            esfa_new_value,
  output logic [7:0]            esfa_metadata,
  output logic [7:0]            esfa_selector,
  input  logic                  esfa_resultBool,
  input  logic [7:0]            esfa_resultValue,
  output logic                  busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Counter only ever holds RESULT_LATENCY-1 down to 0
  localparam int CNT_W = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESULT_LATENCY - 1);

  esfa_state_e            state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       gidx_q, gidx_d;
  logic [CTRL_USED_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]            data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             idx_q, idx_d;
  logic [7:0]             val_q, val_d;
  logic [7:0]             meta_q, meta_d;
  logic [7:0]             sel_q, sel_d;
  logic                   ismeta_q, ismeta_d;
  logic                   rstat_q, rstat_d;
  logic [7:0]             rval_q, rval_d;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [PTR_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [7:0]             slot_ctrl;
  logic [31:0]            slot_data;
  logic                   will_write;
  logic                   unused_ctrl;

  esfa_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Route the picked requester's control byte and data word
  always_comb begin
    slot_ctrl = '0;
    slot_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(pick_idx) == i) begin
        slot_ctrl = req_control[8*i +: 8];
        slot_data = req_data[32*i +: 32];
      end
    end
  end

  // Control bits 7:3 carry no meaning for ESFADesign
  assign unused_ctrl = ^slot_ctrl[7:CTRL_USED_W];

  // Next-state, handshake outputs and operand/response updates
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    ctrl_d     = ctrl_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    val_d      = val_q;
    meta_d     = meta_q;
    sel_d      = sel_q;
    ismeta_d   = ismeta_q;
    rstat_d    = rstat_q;
    rval_d     = rval_q;
    req_ready  = '0;
    rsp_valid  = '0;
    will_write = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          req_ready = pick_grant;
          gidx_d    = pick_idx;
          ctrl_d    = slot_ctrl[CTRL_USED_W-1:0];
          data_d    = slot_data;
          ptr_d     = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
        if (ctrl_q[CTRL_MUTATE]) begin
          if (ctrl_q[CTRL_WRITE]) begin
            // Commit uses the operands already presented to ESFADesign
            will_write = 1'b1;
          end else begin
            idx_d    = data_q[OP_INDEX_LSB +: 8];
            val_d    = data_q[OP_VALUE_LSB +: 8];
            meta_d   = data_q[OP_META_LSB +: 8];
            sel_d    = data_q[OP_SEL_LSB +: 8];
            ismeta_d = ctrl_q[CTRL_META];
          end
        end else begin
          sel_d = data_q[OP_SEL_LSB +: 8];
        end
      end

      ST_WAIT: begin
        if (cnt_q == '0) begin
          rstat_d = ctrl_q[CTRL_MUTATE] ? 1'b1 : esfa_resultBool;
          rval_d  = ctrl_q[CTRL_MUTATE] ? 8'd0 : esfa_resultValue;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RESPOND: begin
        rsp_valid = NUM_REQ'(1) << gidx_q;
        if (rsp_ready[gidx_q]) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command in flight
  always_ff @(posedge masterClock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      ctrl_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      val_q    <= '0;
      meta_q   <= '0;
      sel_q    <= '0;
      ismeta_q <= 1'b0;
      rstat_q  <= 1'b0;
      rval_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
      meta_q   <= meta_d;
      sel_q    <= sel_d;
      ismeta_q <= ismeta_d;
      rstat_q  <= rstat_d;
      rval_q   <= rval_d;
    end
  end

  // Assemble response words and drive ESFADesign from the operand registers
  always_comb begin
    rsp_status                       = '0;
    rsp_status[RSP_STATUS_BIT]       = rstat_q;
    rsp_data                         = '0;
    rsp_data[RSP_VALUE_LSB +: 8]     = rval_q;
    esfa_willWrite                   = will_write;
    esfa_isMetadata                  = ismeta_q;
    esfa_new_index                   = idx_q;
    esfa_new_value                   = val_q;
    esfa_metadata                    = meta_q;
    esfa_selector                    = sel_q;
    busy                             = (state_q != ST_IDLE);
  end

endmodule
